// File: rtl/blend_sequencer.sv
// blend_sequencer
// Frame-level controller for the alpha blending datapath. For each pixel of a
// job it reads src1 and src2 over a shared memory port, hands the pair to the
// blender (pixel_ready/pixel_done), then writes the blended value to dst.
//
// Ports:
//   clk, n_rst            clock; synchronous active-low reset
//   start, abort          job command pulse (IDLE only) / level cancel
//   src1_base, src2_base,
//   dst_base, pixel_count job configuration, latched on an accepted start
//   alpha                 blend weight, legal 0..ALPHA_MAX
//   mem_rd_req/wr_req,
//   mem_addr, mem_wr_data,
//   mem_rd_data, mem_ack  single shared memory port, request held until ack
//   pixel_ready, color1,
//   color2, alpha_value,
//   pixel_done,
//   alpha_result          blender handshake
//   busy, done, err       status: not idle / job complete / start rejected
module blend_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int ALPHA_MAX = 10
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] src1_base,
    input  logic [ADDR_W-1:0] src2_base,
    input  logic [ADDR_W-1:0] dst_base,
    input  logic [ADDR_W-1:0] pixel_count,
    input  logic [3:0]        alpha,
    output logic              mem_rd_req,
    output logic              mem_wr_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wr_data,
    input  logic [7:0]        mem_rd_data,
    input  logic              mem_ack,
    output logic              pixel_ready,
    output logic [7:0]        color1,
    output logic [7:0]        color2,
    output logic [3:0]        alpha_value,
    input  logic              pixel_done,
    input  logic [7:0]        alpha_result,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [3:0]        ALPHA_MAX_L = 4'(ALPHA_MAX);
    localparam logic [ADDR_W-1:0] ONE         = ADDR_W'(1);

    typedef enum logic [2:0] {IDLE, RD1, RD2, BLEND, WR, FIN} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [ADDR_W-1:0] src1_q, src1_d, src2_q, src2_d, dst_q, dst_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [3:0]        alpha_q, alpha_d;
    logic [7:0]        c1_q, c1_d, c2_q, c2_d, res_q, res_d;
    logic              err_q, err_d;

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            alpha_q <= '0;
            c1_q    <= '0;
            c2_q    <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            alpha_q <= alpha_d;
            c1_q    <= c1_d;
            c2_q    <= c2_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        alpha_d = alpha_q;
        c1_d    = c1_q;
        c2_d    = c2_q;
        res_d   = res_q;
        err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (alpha > ALPHA_MAX_L) begin
                        err_d = 1'b1;
                    end else if (pixel_count == '0) begin
                        state_d = FIN;
                    end else begin
                        src1_d  = src1_base;
                        src2_d  = src2_base;
                        dst_d   = dst_base;
                        cnt_d   = pixel_count;
                        alpha_d = alpha;
                        idx_d   = '0;
                        state_d = RD1;
                    end
                end
            end
            RD1: begin
                if (mem_ack) begin
                    c1_d    = mem_rd_data;
                    state_d = RD2;
                end
            end
            RD2: begin
                if (mem_ack) begin
                    c2_d    = mem_rd_data;
                    state_d = BLEND;
                end
            end
            BLEND: begin
                // Leaving BLEND drops pixel_ready, which lets the blender clear done.
                if (pixel_done) begin
                    res_d   = alpha_result;
                    state_d = WR;
                end
            end
            WR: begin
                if (mem_ack) begin
                    if (idx_q == cnt_q - ONE) begin
                        state_d = FIN;
                    end else begin
                        idx_d   = idx_q + ONE;
                        state_d = RD1;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
        end
    end

    // Requests and addresses are decoded from the registered state, so they stay
    // stable while waiting for ack and drop the cycle after it.
    always_comb begin
        mem_addr = '0;
        case (state_q)
            RD1:     mem_addr = src1_q + idx_q;
            RD2:     mem_addr = src2_q + idx_q;
            WR:      mem_addr = dst_q + idx_q;
            default: mem_addr = '0;
        endcase
    end

    assign mem_rd_req  = (state_q == RD1) || (state_q == RD2);
    assign mem_wr_req  = (state_q == WR);
    assign mem_wr_data = (state_q == WR) ? res_q : 8'h00;
    assign pixel_ready = (state_q == BLEND);
    assign color1      = c1_q;
    assign color2      = c2_q;
    assign alpha_value = alpha_q;
    assign busy        = (state_q != IDLE);
    // An abort landing in FIN cancels the completion pulse.
    assign done        = (state_q == FIN) && !abort;
    assign err         = err_q;

endmodule

// File: tb/tb_blend_sequencer.sv
module tb_blend_sequencer;

    logic        clk = 1'b0;
    logic        n_rst, start, abort;
    logic [15:0] src1_base, src2_base, dst_base, pixel_count;
    logic [3:0]  alpha;
    logic        mem_rd_req, mem_wr_req, mem_ack;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wr_data, mem_rd_data;
    logic        pixel_ready, pixel_done;
    logic [7:0]  color1, color2, alpha_result;
    logic [3:0]  alpha_value;
    logic        busy, done, err;

    int errors = 0;
    int checks = 0;

    blend_sequencer #(.ADDR_W(16), .ALPHA_MAX(10)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .abort(abort),
        .src1_base(src1_base), .src2_base(src2_base), .dst_base(dst_base),
        .pixel_count(pixel_count), .alpha(alpha),
        .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
        .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data), .mem_ack(mem_ack),
        .pixel_ready(pixel_ready), .color1(color1), .color2(color2),
        .alpha_value(alpha_value), .pixel_done(pixel_done),
        .alpha_result(alpha_result), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // ---------------- memory model with programmable wait states ----------------
    logic [7:0]  mem [0:65535];
    int          mem_delay = 0;
    int          wait_cnt  = 0;
    int          rd_cnt = 0, wr_cnt = 0, done_cnt = 0, pr_cnt = 0, err_cnt = 0;
    int          stab_err = 0, onehot_err = 0;
    logic [15:0] wr_addr_log[$];
    logic [7:0]  wr_data_log[$];
    logic        pend_q = 1'b0;
    logic        pend_rd = 1'b0;
    logic [15:0] hold_addr = '0;
    logic [7:0]  hold_data = '0;

    assign mem_ack     = (mem_rd_req || mem_wr_req) && (wait_cnt >= mem_delay);
    assign mem_rd_data = mem[mem_addr];

    always @(posedge clk) begin
        if ((mem_rd_req || mem_wr_req) && !mem_ack) wait_cnt <= wait_cnt + 1;
        else                                         wait_cnt <= 0;
        if (mem_rd_req && mem_ack) rd_cnt <= rd_cnt + 1;
        if (mem_wr_req && mem_ack) begin
            wr_cnt <= wr_cnt + 1;
            mem[mem_addr] <= mem_wr_data;
            wr_addr_log.push_back(mem_addr);
            wr_data_log.push_back(mem_wr_data);
        end
        if (mem_rd_req && mem_wr_req) onehot_err <= onehot_err + 1;
        // A request left pending at the last edge must still be present, unchanged.
        if (pend_q && n_rst && !abort) begin
            if (mem_addr !== hold_addr || (pend_rd ? !mem_rd_req : !mem_wr_req) ||
                (!pend_rd && mem_wr_data !== hold_data))
                stab_err <= stab_err + 1;
        end
        pend_q    <= (mem_rd_req || mem_wr_req) && !mem_ack;
        pend_rd   <= mem_rd_req;
        hold_addr <= mem_addr;
        hold_data <= mem_wr_data;
        if (done)        done_cnt <= done_cnt + 1;
        if (err)         err_cnt  <= err_cnt + 1;
        if (pixel_ready) pr_cnt   <= pr_cnt + 1;
    end

    // ---------------- behavioural blender ----------------
    always @(posedge clk) begin
        if (!n_rst) begin
            pixel_done   <= 1'b0;
            alpha_result <= 8'h00;
        end else begin
            pixel_done <= pixel_ready && !pixel_done;
            if (pixel_ready && !pixel_done)
                alpha_result <= 8'((int'(color1) * int'(alpha_value) +
                                    int'(color2) * (10 - int'(alpha_value))) / 10);
        end
    end

    // ---------------- helpers ----------------
    task automatic cfg(input logic [15:0] d, input logic [15:0] n, input logic [3:0] a);
        src1_base = 16'h0100; src2_base = 16'h0200; dst_base = d;
        pixel_count = n; alpha = a;
    endtask

    // Pulse start; returns the cycle (1 = first cycle after start) done was seen.
    task automatic run_job(input int budget, output int cyc);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; cyc = 1;
        while (!done && cyc < budget) begin
            @(negedge clk); cyc++;
        end
    endtask

    task automatic load_mem();
        mem[16'h0100] = 8'd20; mem[16'h0101] = 8'd40;
        mem[16'h0200] = 8'd40; mem[16'h0201] = 8'd0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_rst = 1'b0; start = 1'b0; abort = 1'b0; cfg(16'h0300, 16'd0, 4'd0);
        repeat (2) @(negedge clk);
        checks++;
        if ({mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, pixel_ready, color1, color2,
             alpha_value, busy, done, err} !== '0) begin
            errors++; $display("FAIL reset_outputs: some output nonzero (addr=%h busy=%b)", mem_addr, busy);
        end
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int cyc; int wb;
        load_mem(); cfg(16'h0300, 16'd2, 4'd5);
        wb = wr_addr_log.size();
        run_job(60, cyc);
        checks++;
        if (cyc !== 11 || !done) begin
            errors++; $display("FAIL basic_latency: got %0d done=%b, want 11", cyc, done);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL basic_idle_after: busy=%b done=%b, want 0 0", busy, done);
        end
        checks++;
        if (wr_addr_log.size() !== wb + 2 || wr_addr_log[wb] !== 16'h0300 || wr_data_log[wb] !== 8'd30 ||
            wr_addr_log[wb+1] !== 16'h0301 || wr_data_log[wb+1] !== 8'd20) begin
            errors++; $display("FAIL basic_writes: n=%0d, want 2 writes 0300:30 0301:20", wr_addr_log.size() - wb);
        end
    endtask

    task automatic test_wait_states();
        int cyc; int wb, rb, wc;
        load_mem(); cfg(16'h0300, 16'd2, 4'd5); mem_delay = 3;
        wb = wr_addr_log.size(); rb = rd_cnt; wc = wr_cnt;
        run_job(200, cyc);
        checks++;
        if (!done) begin
            errors++; $display("FAIL wait_done: timeout at %0d cycles", cyc);
        end
        @(negedge clk);
        mem_delay = 0;
        checks++;
        if (wr_addr_log.size() !== wb + 2 || wr_addr_log[wb] !== 16'h0300 || wr_data_log[wb] !== 8'd30 ||
            wr_addr_log[wb+1] !== 16'h0301 || wr_data_log[wb+1] !== 8'd20) begin
            errors++; $display("FAIL wait_writes: n=%0d, want 0300:30 0301:20", wr_addr_log.size() - wb);
        end
        checks++;
        if (rd_cnt - rb !== 4 || wr_cnt - wc !== 2) begin
            errors++; $display("FAIL wait_counts: reads=%0d writes=%0d, want 4 2", rd_cnt - rb, wr_cnt - wc);
        end
        checks++;
        if (stab_err !== 0 || onehot_err !== 0) begin
            errors++; $display("FAIL wait_stable: stab=%0d onehot=%0d, want 0 0", stab_err, onehot_err);
        end
    endtask

    task automatic test_illegal_alpha();
        int rb, wc, db, eb;
        cfg(16'h0300, 16'd2, 4'd11);
        rb = rd_cnt; wc = wr_cnt; db = done_cnt; eb = err_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL alpha_err: err=%b busy=%b, want 1 0", err, busy);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (err_cnt - eb !== 1 || busy !== 1'b0 || rd_cnt !== rb || wr_cnt !== wc || done_cnt !== db) begin
            errors++; $display("FAIL alpha_quiet: errs=%0d busy=%b rd=%0d wr=%0d done=%0d, want 1 0 0 0 0",
                               err_cnt - eb, busy, rd_cnt - rb, wr_cnt - wc, done_cnt - db);
        end
    endtask

    task automatic test_zero_count();
        int cyc, rb, wc, pb;
        cfg(16'h0300, 16'd0, 4'd4);
        rb = rd_cnt; wc = wr_cnt; pb = pr_cnt;
        run_job(20, cyc);
        checks++;
        if (cyc !== 1 || !done) begin
            errors++; $display("FAIL zero_latency: got %0d done=%b, want 1", cyc, done);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (rd_cnt !== rb || wr_cnt !== wc || pr_cnt !== pb || busy !== 1'b0) begin
            errors++; $display("FAIL zero_quiet: rd=%0d wr=%0d ready=%0d busy=%b, want 0 0 0 0",
                               rd_cnt - rb, wr_cnt - wc, pr_cnt - pb, busy);
        end
    endtask

    task automatic test_abort();
        int n, rb, wc, db;
        load_mem(); cfg(16'h0300, 16'd8, 4'd5);
        wc = wr_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!(pixel_ready && wr_cnt - wc == 3) && n < 100) begin
            @(negedge clk); n++;
        end
        checks++;
        if (n >= 100) begin
            errors++; $display("FAIL abort_reach: BLEND of pixel 3 not reached, got %0d want <100", n);
        end
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || mem_rd_req !== 1'b0 || mem_wr_req !== 1'b0 || pixel_ready !== 1'b0) begin
            errors++; $display("FAIL abort_idle: busy=%b rd=%b wr=%b rdy=%b, want 0", busy, mem_rd_req, mem_wr_req, pixel_ready);
        end
        rb = rd_cnt; wc = wr_cnt; db = done_cnt;
        repeat (20) @(negedge clk);
        checks++;
        if (rd_cnt !== rb || wr_cnt !== wc || done_cnt !== db) begin
            errors++; $display("FAIL abort_quiet: rd=%0d wr=%0d done=%0d, want 0 0 0", rd_cnt - rb, wr_cnt - wc, done_cnt - db);
        end
        test_basic();
    endtask

    task automatic test_reset_mid_job();
        int n;
        load_mem(); cfg(16'h0300, 16'd8, 4'd5);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!pixel_ready && n < 50) begin
            @(negedge clk); n++;
        end
        n_rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mem_rd_req, mem_wr_req, mem_addr, mem_wr_data, pixel_ready, color1, color2,
             alpha_value, busy, done, err} !== '0) begin
            errors++; $display("FAIL midreset_outputs: busy=%b c1=%0d c2=%0d a=%0d, want all 0",
                               busy, color1, color2, alpha_value);
        end
        n_rst = 1'b1;
        @(negedge clk);
        test_basic();
    endtask

    task automatic test_wrap();
        int cyc; int wb;
        load_mem(); cfg(16'hFFFF, 16'd2, 4'd5);
        wb = wr_addr_log.size();
        run_job(60, cyc);
        @(negedge clk);
        checks++;
        if (wr_addr_log.size() !== wb + 2 || wr_addr_log[wb] !== 16'hFFFF || wr_addr_log[wb+1] !== 16'h0000 ||
            wr_data_log[wb] !== 8'd30 || wr_data_log[wb+1] !== 8'd20) begin
            errors++; $display("FAIL wrap_writes: n=%0d, want FFFF:30 0000:20", wr_addr_log.size() - wb);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wait_states();
        test_illegal_alpha();
        test_zero_count();
        test_abort();
        test_reset_mid_job();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/blend_sequencer.md
Name: blend_sequencer

Overview:
Frame-level controller for the alpha blending pixel datapath. It walks a span of pixels in two source buffers and fetches each pair over one shared memory port. It hands each pair to the blender using the blender's pixel_ready/pixel_done handshake, then writes the blended result to a destination buffer. It sits between the GPU command decoder (start/configuration) and the SRAM arbiter port.

Parameters:
ADDR_W, 16, width of all addresses and of pixel_count; address arithmetic wraps modulo 2^ADDR_W
ALPHA_MAX, 10, largest legal alpha; blender weights are alpha/ALPHA_MAX and (ALPHA_MAX-alpha)/ALPHA_MAX

Ports:
clk  in  1  system clock, all state on rising edge
n_rst  in  1  reset, synchronous, active-low
start  in  1  single-cycle command pulse; sampled only in IDLE
abort  in  1  level; cancels the running job
src1_base  in  ADDR_W  first source (foreground) buffer base address
src2_base  in  ADDR_W  second source (background) buffer base address
dst_base  in  ADDR_W  destination buffer base address
pixel_count  in  ADDR_W  number of pixels in the job
alpha  in  4  blend weight, legal 0..ALPHA_MAX
mem_rd_req  out  1  read request, held until mem_ack
mem_wr_req  out  1  write request, held until mem_ack
mem_addr  out  ADDR_W  request address
mem_wr_data  out  8  write data
mem_rd_data  in  8  read data, valid in the mem_ack cycle of a read
mem_ack  in  1  completes the current request; may be high in the same cycle as the request
pixel_ready  out  1  to blender: operands valid, blend requested
color1  out  8  to blender, pixel from src1
color2  out  8  to blender, pixel from src2
alpha_value  out  4  to blender, latched alpha
pixel_done  in  1  from blender, registered, high the cycle after pixel_ready is sampled
alpha_result  in  8  from blender, valid while pixel_done=1
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a job completes normally
err  out  1  one-cycle pulse when a start is rejected

Behaviour:
- Reset (n_rst=0 at a clk edge): FSM to IDLE. All outputs 0: req lines, mem_addr, mem_wr_data, pixel_ready, color1/2, alpha_value, busy, done, err. Pixel index cleared. Reset mid-job abandons it with no done pulse.
- States: IDLE, RD1, RD2, BLEND, WR, FIN.
- IDLE:
  - start=1 with alpha>ALPHA_MAX: err=1 next cycle, remain IDLE.
  - start=1 with pixel_count=0: go to FIN, no memory traffic.
  - Otherwise: latch all bases, count and alpha; clear idx; go to RD1.
  - start is ignored in every other state.
- RD1: mem_rd_req=1, mem_addr=src1_base+idx. On mem_ack: capture color1, go to RD2.
- RD2: mem_rd_req=1, mem_addr=src2_base+idx. On mem_ack: capture color2, go to BLEND.
- BLEND: pixel_ready=1 and color1/color2/alpha_value stable. On pixel_done=1: capture alpha_result, go to WR with pixel_ready=0 so the blender clears done.
- WR: mem_wr_req=1, mem_addr=dst_base+idx, mem_wr_data=captured result (unmodified). On mem_ack: if idx==count-1 go to FIN, else idx+1 and go to RD1.
- FIN: done=1 for exactly one cycle, then IDLE.
- Memory requests:
  - Only one request line is high at a time.
  - Address and data are stable from request until ack.
  - The request drops in the cycle after the ack.
- Latency: with zero-wait memory (ack in the request cycle), each pixel takes 5 cycles (RD1, RD2, BLEND×2, WR). A job takes 5·N+1 cycles from the cycle after start to done, inclusive of FIN.
- abort=1 in any non-IDLE state:
  - Next state is IDLE, all req/pixel_ready dropped, no done pulse.
  - A write acked in the same cycle as abort counts as completed.
- pixel_count=2^ADDR_W-1 with base near the top of the address space: addresses wrap to 0, with no error.

Test Plan:
- Basic job: src1=0x0100, src2=0x0200, dst=0x0300, count=2, alpha=5, memory {0x0100:20, 0x0101:40, 0x0200:40, 0x0201:0}, behavioural blender -> writes 30 to 0x0300 and 20 to 0x0301, done pulse 11 cycles after start, busy low after.
- Wait states: same job with ack delayed 3 cycles on every request -> identical writes; req/addr/data stable while waiting; exactly 4 reads and 2 writes.
- Illegal alpha: start with alpha=11 -> err=1 for one cycle, busy stays 0, no memory requests, no done.
- Zero count: start with pixel_count=0, alpha=4 -> done 1 cycle later, no requests, pixel_ready never asserted.
- Abort and reset mid-job: count=8, abort asserted in BLEND of pixel 3 -> IDLE next cycle, no further requests, no done, and a new start runs cleanly. Repeat with n_rst=0 instead of abort -> all outputs 0 after the edge.
- Wrap: dst_base=0xFFFF, count=2 -> writes to 0xFFFF then 0x0000.
